// File: rtl/ips2l_ddrphy_ppll_seq_v1_1.sv
// rtl/ips2l_ddrphy_ppll_seq_v1_1.sv - DDR PHY PPLL reset/lock sequencer with retry and staggered clock gating
module ips2l_ddrphy_ppll_seq_v1_1 #(
    parameter int NUM_GATES          = 2,
    parameter int RST_CYCLES         = 16,
    parameter int LOCK_STABLE_CYCLES = 64,
    parameter int LOCK_TIMEOUT       = 4096,
    parameter int MAX_RETRY          = 3,
    parameter int GATE_STAGGER       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 pll_lock,
    output logic                 pll_rst,
    output logic [NUM_GATES-1:0] gate_en,
    output logic                 ready,
    output logic                 error,
    output logic                 lock_lost,
    output logic [3:0]           retry_cnt,
    output logic [2:0]           state
);

    localparam int CNT_MAX0 = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > GATE_STAGGER) ? CNT_MAX0 : GATE_STAGGER;
    localparam int CW       = $clog2(CNT_MAX) + 1;
    localparam int TW       = $clog2(LOCK_TIMEOUT) + 1;
    localparam int GW       = $clog2(NUM_GATES) + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_GATE_ON   = 3'd4,
        S_RUN       = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    state_t               cur, nxt;
    logic                 lock_meta, lock_s;
    logic [CW-1:0]        cnt, cnt_d;
    logic [TW-1:0]        to_cnt, to_d;
    logic [GW-1:0]        gate_idx, gidx_d;
    logic                 pll_rst_d, ready_d, error_d, lost_d, timeout;
    logic [NUM_GATES-1:0] gate_d;
    logic [3:0]           retry_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= S_IDLE;
            cnt       <= '0;
            to_cnt    <= '0;
            gate_idx  <= '0;
            pll_rst   <= 1'b1;
            gate_en   <= '0;
            ready     <= 1'b0;
            error     <= 1'b0;
            lock_lost <= 1'b0;
            retry_cnt <= '0;
        end else begin
            cur       <= nxt;
            cnt       <= cnt_d;
            to_cnt    <= to_d;
            gate_idx  <= gidx_d;
            pll_rst   <= pll_rst_d;
            gate_en   <= gate_d;
            ready     <= ready_d;
            error     <= error_d;
            lock_lost <= lost_d;
            retry_cnt <= retry_d;
        end
    end

    assign state = cur;

    // cnt is shared: RESET hold time, STABLE run length, and GATE_ON stagger spacing
    always_comb begin
        nxt       = cur;
        cnt_d     = cnt;
        to_d      = to_cnt;
        gidx_d    = gate_idx;
        pll_rst_d = pll_rst;
        gate_d    = gate_en;
        ready_d   = ready;
        error_d   = error;
        lost_d    = 1'b0;
        retry_d   = retry_cnt;
        timeout   = (to_cnt == TW'(LOCK_TIMEOUT - 1));
        if (!start) begin
            nxt       = S_IDLE;
            pll_rst_d = 1'b1;
            gate_d    = '0;
            ready_d   = 1'b0;
            error_d   = 1'b0;
        end else begin
            case (cur)
                S_IDLE: begin
                    nxt       = S_RESET;
                    cnt_d     = '0;
                    retry_d   = '0;
                    error_d   = 1'b0;
                    pll_rst_d = 1'b1;
                end
                S_RESET: begin
                    pll_rst_d = 1'b1;
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        nxt       = S_WAIT_LOCK;
                        pll_rst_d = 1'b0;
                        to_d      = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK, S_STABLE: begin
                    to_d = to_cnt + 1'b1;
                    if (timeout) begin
                        to_d      = to_cnt;
                        cnt_d     = '0;
                        pll_rst_d = 1'b1;
                        if (retry_cnt == 4'(MAX_RETRY)) begin
                            nxt     = S_FAIL;
                            error_d = 1'b1;
                        end else begin
                            nxt     = S_RESET;
                            retry_d = retry_cnt + 4'd1;
                        end
                    end else if (!lock_s) begin
                        nxt = S_WAIT_LOCK;
                    end else if (cur == S_WAIT_LOCK) begin
                        nxt   = S_STABLE;
                        cnt_d = '0;
                    end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
                        nxt    = S_GATE_ON;
                        cnt_d  = '0;
                        gidx_d = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                S_GATE_ON, S_RUN: begin
                    if (!lock_s) begin
                        nxt       = S_RESET;
                        cnt_d     = '0;
                        pll_rst_d = 1'b1;
                        gate_d    = '0;
                        ready_d   = 1'b0;
                        lost_d    = 1'b1;
                    end else if (cur == S_RUN) begin
                        retry_d = '0;
                    end else if (cnt == CW'(GATE_STAGGER - 1)) begin
                        cnt_d  = '0;
                        gate_d = gate_en | (NUM_GATES'(1) << gate_idx);
                        gidx_d = gate_idx + 1'b1;
                        if (gate_idx == GW'(NUM_GATES - 1)) begin
                            nxt     = S_RUN;
                            ready_d = 1'b1;
                            retry_d = '0;
                        end
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                S_FAIL: begin
                    pll_rst_d = 1'b1;
                    gate_d    = '0;
                    error_d   = 1'b1;
                end
                default: nxt = S_IDLE;
            endcase
        end
    end

endmodule
